ld_to_affine: RTL and testbench

- Sequential converter that takes a López-Dahab projective point (X, Y, Z) over GF(2^4) and returns the affine point (x, y), where x = X/Z and y = Y/Z^2.
- It sits directly downstream of the point-addition/doubling datapath and consumes its (X2, Y2, Z2) outputs.
- It computes Z^-1 = Z^14 by iterative square-and-multiply, reusing one squarer and one multiplier.
- It flags the point at infinity (Z = 0).

---
 rtl/gf16_pkg.sv | 23 ++
 rtl/fourbit_MMult.sv | 25 ++
 rtl/fourbit_SQR.sv | 12 +
 rtl/gf16_inv_seq.sv | 63 ++++++
 rtl/ld_to_affine.sv | 120 ++++++++++++
 tb/tb_ld_to_affine.sv | 268 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/gf16_pkg.sv
// Shared GF(2^4) constants, inversion schedule and converter FSM encoding.
// Field is GF(2^4) with reduction polynomial x^4 + x + 1.
package gf16_pkg;

    localparam int W = 4;

    // Low bits of x^4 + x + 1; x^4 folds back to x + 1 on reduction.
    localparam logic [W-1:0] RED_POLY = 4'b0011;

    // Z^-1 = Z^14, exponent 1110b processed MSB-first after loading r = Z.
    // Bit i selects whether step i multiplies by Z (steps 0,1 yes, step 2 no).
    localparam int                   INV_STEPS = 3;
    localparam logic [INV_STEPS-1:0] INV_USE_Z = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        INV,
        MULX,
        MULY,
        DONE
    } state_t;

endpackage

// File: rtl/fourbit_MMult.sv
// GF(2^4) multiplier: shift-and-add with reduction mod x^4 + x + 1.
module fourbit_MMult
    import gf16_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p
);

    logic [W-1:0] acc;
    logic [W-1:0] sh;

    // NOTE: blocking assignments here build a ripple of partial products within
    // one evaluation; every variable gets a default first so no latch is inferred.
    always_comb begin
        acc = '0;
        sh  = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[W-2:0], 1'b0} ^ (sh[W-1] ? RED_POLY : '0);
        end
        p = acc;
    end

endmodule

// File: rtl/fourbit_SQR.sv
// GF(2^4) squarer: squaring is linear in characteristic 2, so it is pure XOR wiring.
module fourbit_SQR
    import gf16_pkg::*;
(
    input  logic [W-1:0] a,
    output logic [W-1:0] s
);

    // a^2 = a0 + a1 x^2 + a2 x^4 + a3 x^6, with x^4 = x+1 and x^6 = x^3+x^2.
    assign s = {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};

endmodule

// File: rtl/gf16_inv_seq.sv
// Three-cycle Z^14 exponentiator: r <= sq(r) * (use_z ? Z : 1), starting from r = Z.
// Produces Z^3, Z^7, Z^14; Z = 0 naturally yields 0.
module gf16_inv_seq
    import gf16_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] z,
    output logic [W-1:0] r,
    output logic [W-1:0] z_hold,
    output logic         done
);

    localparam logic [1:0]   LAST_STEP = 2'(INV_STEPS - 1);
    localparam logic [W-1:0] ONE       = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_q;
    logic [W-1:0] z_q;
    logic [W-1:0] r_sq;
    logic [W-1:0] mul_b;
    logic [W-1:0] r_next;
    logic [1:0]   step;
    logic         busy;

    fourbit_SQR u_sqr (
        .a (r_q),
        .s (r_sq)
    );

    assign mul_b = INV_USE_Z[step] ? z_q : ONE;

    fourbit_MMult u_mul (
        .a (r_sq),
        .b (mul_b),
        .p (r_next)
    );

    assign done   = busy && (step == LAST_STEP);
    assign r      = r_q;
    assign z_hold = z_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q  <= '0;
            z_q  <= '0;
            step <= '0;
            busy <= 1'b0;
        end else if (start) begin
            r_q  <= z;
            z_q  <= z;
            step <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            r_q <= r_next;
            if (done) busy <= 1'b0;
            else      step <= step + 2'd1;
        end
    end

endmodule

// File: rtl/ld_to_affine.sv
// Lopez-Dahab projective (X, Y, Z) to affine (X/Z, Y/Z^2) converter over GF(2^4).
// Accept -> 3 inversion steps -> MULX -> MULY -> DONE (held until out_ready).
module ld_to_affine #(
    parameter int W        = 4,
    parameter bit INF_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X_i,
    input  logic [W-1:0] Y_i,
    input  logic [W-1:0] Z_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic         inf_o
);
    import gf16_pkg::*;

    state_t       state;
    state_t       state_next;

    logic [W-1:0] x_q;
    logic [W-1:0] y_q;
    logic [W-1:0] x_reg;
    logic [W-1:0] r2;
    logic [W-1:0] r;
    logic [W-1:0] z_hold;
    logic [W-1:0] r_sq;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] prod;
    logic         accept;
    logic         inv_done;
    logic         z_zero;
    logic         force_zero;

    assign accept = in_valid && in_ready;

    gf16_inv_seq u_inv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .z      (Z_i),
        .r      (r),
        .z_hold (z_hold),
        .done   (inv_done)
    );

    // r2 = Z^-2 is squared from Z^-1 in MULX and consumed in MULY.
    fourbit_SQR u_sqr_r2 (
        .a (r),
        .s (r_sq)
    );

    // One multiplier serves both MULX (X * Z^-1) and MULY (Y * Z^-2).
    assign mul_a = (state == MULY) ? y_q : x_q;
    assign mul_b = (state == MULY) ? r2  : r;

    fourbit_MMult u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (prod)
    );

    assign z_zero     = (z_hold == '0);
    assign force_zero = INF_ZERO && z_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = INV;
            INV:     if (inv_done)  state_next = MULX;
            MULX:                   state_next = MULY;
            MULY:                   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // DONE never reports ready, so a result handshake and a new accept cannot share an edge.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            x_reg <= '0;
            r2    <= '0;
            x_o   <= '0;
            y_o   <= '0;
            inf_o <= 1'b0;
        end else begin
            if (accept) begin
                x_q <= X_i;
                y_q <= Y_i;
            end
            if (state == MULX) begin
                x_reg <= prod;
                r2    <= r_sq;
            end
            if (state == MULY) begin
                x_o   <= force_zero ? '0 : x_reg;
                y_o   <= force_zero ? '0 : prod;
                inf_o <= z_zero;
            end
        end
    end

endmodule

// File: tb/tb_ld_to_affine.sv
// Self-checking bench for ld_to_affine: log/antilog GF(2^4) model, per-cycle
// scoreboard compare, directed cases from hand-computed values, then random traffic.
module tb_ld_to_affine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] X_i = '0;
    logic [3:0] Y_i = '0;
    logic [3:0] Z_i = '0;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] x_o;
    logic [3:0] y_o;
    logic       inf_o;

    ld_to_affine #(.W(4), .INF_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X_i       (X_i),
        .Y_i       (Y_i),
        .Z_i       (Z_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_o       (x_o),
        .y_o       (y_o),
        .inf_o     (inf_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       inf;
        int         acc;
    } exp_t;

    exp_t       q[$];
    logic [3:0] exp_tab[15];
    int         log_tab[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // x generates the multiplicative group of GF(16) under x^4+x+1.
    task automatic build_tables();
        logic [3:0] v;
        v = 4'd1;
        for (int i = 0; i < 15; i++) begin
            exp_tab[i] = v;
            log_tab[v] = i;
            v = {v[2:0], 1'b0} ^ (v[3] ? 4'b0011 : 4'b0000);
        end
    endtask

    function automatic logic [3:0] gmul(input logic [3:0] a, input logic [3:0] b);
        if (a == 0 || b == 0) return 4'd0;
        return exp_tab[(log_tab[a] + log_tab[b]) % 15];
    endfunction

    function automatic logic [3:0] ginv(input logic [3:0] z);
        return exp_tab[(15 - log_tab[z]) % 15];
    endfunction

    function automatic exp_t model(input logic [3:0] xx, input logic [3:0] yy, input logic [3:0] zz);
        exp_t e;
        logic [3:0] zi;
        e.acc = 0;
        e.inf = (zz == 0);
        if (e.inf) begin
            e.x = 4'd0;
            e.y = 4'd0;
        end else begin
            zi  = ginv(zz);
            e.x = gmul(xx, zi);
            e.y = gmul(yy, gmul(zi, zi));
        end
        return e;
    endfunction

    // Scoreboard update on handshakes; an async reset discards the in-flight point.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_t e;
            cyc++;
            if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready) begin
                e     = model(X_i, Y_i, Z_i);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    // Per-cycle compare: result valid exactly 5 edges after accept, held until taken.
    always @(negedge clk) begin
        logic exp_v;
        if (!rst_n) begin
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_x", x_o, 0);
            check("rst_y", y_o, 0);
            check("rst_inf", inf_o, 0);
        end else begin
            exp_v = 1'b0;
            if (q.size() > 0) exp_v = ((cyc - q[0].acc) >= 5);
            check("in_ready", in_ready, q.size() == 0);
            check("out_valid", out_valid, exp_v);
            if (exp_v && out_valid) begin
                check("x_o", x_o, q[0].x);
                check("y_o", y_o, q[0].y);
                check("inf_o", inf_o, q[0].inf);
            end
        end
    end

    // Called and returns at negedge+1.
    task automatic send(input logic [3:0] xx, input logic [3:0] yy, input logic [3:0] zz,
                        output int acc);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        X_i      = xx;
        Y_i      = yy;
        Z_i      = zz;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            if (in_ready) got = 1'b1;
        end
        #1;
        acc = cyc;
        if (!got) check("send_timeout", 0, 1);
        in_valid = 1'b0;
        X_i      = 4'($urandom);
        Y_i      = 4'($urandom);
        Z_i      = 4'($urandom);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(input int acc, input string tag, input logic [3:0] ex,
                            input logic [3:0] ey, input logic einf);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_latency"}, cyc - acc, 5);
            check({tag, "_x"}, x_o, ex);
            check({tag, "_y"}, y_o, ey);
            check({tag, "_inf"}, inf_o, einf);
        end
        #1;
    endtask

    initial begin
        int a1;
        int a2;
        int zr;

        build_tables();
        check("model_inv2", ginv(4'd2), 4'h9);
        check("model_inv3", ginv(4'd3), 4'hE);
        check("model_mul7b", gmul(4'd7, 4'hB), 4'h4);

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Z=2: Z^-1=9, Z^-2=D.
        out_ready = 1'b1;
        send(4'd2, 4'd4, 4'd2, a1);
        wait_out(a1, "z2", 4'd1, 4'd1, 1'b0);

        // Z=3 followed immediately by Z=1 pass-through.
        send(4'd3, 4'd7, 4'd3, a1);
        wait_out(a1, "z3", 4'd1, 4'd4, 1'b0);
        send(4'd5, 4'hA, 4'd1, a2);
        check("b2b_interval", a2 - a1, 7);
        wait_out(a2, "z1", 4'd5, 4'hA, 1'b0);

        // Point at infinity.
        send(4'd6, 4'd9, 4'd0, a1);
        wait_out(a1, "zinf", 4'd0, 4'd0, 1'b1);
        @(negedge clk);
        #1;

        // Backpressure: result must hold for 10 cycles.
        out_ready = 1'b0;
        send(4'd3, 4'd7, 4'd3, a1);
        wait_out(a1, "bp", 4'd1, 4'd4, 1'b0);
        repeat (10) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_x", x_o, 4'd1);
            check("bp_hold_y", y_o, 4'd4);
        end
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        #1;

        // Async reset during INV step 1.
        send(4'd9, 4'd5, 4'd7, a1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_x", x_o, 0);
        check("arst_y", y_o, 0);
        check("arst_inf", inf_o, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("no_stale_valid", out_valid, 0);
        end
        #1;
        // Z=5: Z^-1=B, Z^-2=9.
        send(4'd7, 4'd3, 4'd5, a1);
        wait_out(a1, "post_rst", 4'd4, 4'd8, 1'b0);

        // Random traffic with Z=0 and Z=1 biased in.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            X_i       = 4'($urandom);
            Y_i       = 4'($urandom);
            zr        = int'($urandom_range(0, 7));
            Z_i       = (zr == 0) ? 4'd0 : (zr == 1) ? 4'd1 : 4'($urandom);
            @(negedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
